// File: rtl/seg7_scan.sv
// Two-digit multiplexed hex 7-segment driver fed by a valid/ready handshake.
// Optional leading-zero blanking of the high digit: define SEG7_SCAN_BLANK_EN.
module seg7_scan #(
  parameter int PRESCALE     = 16,
  parameter int BLANK_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] data_in,
  input  logic [1:0] dp_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic [6:0] seg,
  output logic       dp,
  output logic [1:0] dig_sel_n
);

  // state    | meaning
  // LO_BLANK | low digit slot, anti-ghosting blank window
  // LO_ON    | low digit lit
  // HI_BLANK | high digit slot, anti-ghosting blank window
  // HI_ON    | high digit lit; its last cycle completes the frame
  typedef enum logic [1:0] {LO_BLANK, LO_ON, HI_BLANK, HI_ON} state_t;

  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [7:0]    cap;
  logic [1:0]    cap_dp;
  logic          rdy_q;

  logic          wrap;
  logic          last_hi;
  logic          xfer;
  logic          hi_next;
  logic          blank_next;
  logic [CW-1:0] nxt_cnt;
  state_t        nxt_state;
  state_t        start_state;
  state_t        out_state;
  logic [7:0]    out_val;
  logic [1:0]    out_dp;
  logic [6:0]    seg_d;
  logic          dp_d;
  logic [1:0]    dig_d;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Ready also rises during the final HI_ON cycle so the next transfer
  // lands exactly one frame after the previous one.
  assign last_hi    = (state == HI_ON) && wrap;
  assign data_ready = ena & (rdy_q | last_hi);
  assign xfer       = data_valid & data_ready;

  always_comb begin
    wrap        = (cnt == CNT_LAST);
    nxt_cnt     = wrap ? '0 : cnt + CW'(1);
    blank_next  = int'(nxt_cnt) < BLANK_CYCLES;
    hi_next     = ((state == HI_ON) || (state == HI_BLANK)) ^ wrap;
    if (hi_next) nxt_state = blank_next ? HI_BLANK : HI_ON;
    else         nxt_state = blank_next ? LO_BLANK : LO_ON;
    start_state = (BLANK_CYCLES > 0) ? LO_BLANK : LO_ON;
    out_state   = xfer ? start_state : nxt_state;
    out_val     = xfer ? data_in : cap;
    out_dp      = xfer ? dp_in : cap_dp;
  end

  // Output decode works on the upcoming state so the registered outputs
  // line up with the state register.
  always_comb begin
    seg_d = 7'h00;
    dp_d  = 1'b0;
    dig_d = 2'b11;
    case (out_state)
      LO_ON: begin
        seg_d = hex7(out_val[3:0]);
        dp_d  = out_dp[0];
        dig_d = 2'b10;
      end
      HI_ON: begin
`ifdef SEG7_SCAN_BLANK_EN
        if ((out_val[7:4] != 4'h0) || out_dp[1]) begin
          seg_d = hex7(out_val[7:4]);
          dp_d  = out_dp[1];
          dig_d = 2'b01;
        end
`else
        seg_d = hex7(out_val[7:4]);
        dp_d  = out_dp[1];
        dig_d = 2'b01;
`endif
      end
      default: begin
        seg_d = 7'h00;
        dp_d  = 1'b0;
        dig_d = 2'b11;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LO_BLANK;
      cnt       <= '0;
      cap       <= 8'h00;
      cap_dp    <= 2'b00;
      rdy_q     <= 1'b1;
      seg       <= 7'h00;
      dp        <= 1'b0;
      dig_sel_n <= 2'b11;
    end else if (ena) begin
      if (xfer) begin
        cap    <= data_in;
        cap_dp <= dp_in;
        state  <= start_state;
        cnt    <= '0;
        rdy_q  <= 1'b0;
      end else begin
        state <= nxt_state;
        cnt   <= nxt_cnt;
        if (last_hi) rdy_q <= 1'b1;
      end
      seg       <= seg_d;
      dp        <= dp_d;
      dig_sel_n <= dig_d;
    end
  end

endmodule
